id_operand_stage: RTL and testbench

Decode-to-execute operand stage sitting directly downstream of the register file. It drives the two regfile read addresses, captures `r_data1`/`r_data2` together with the decoded instruction fields, and presents them to execute through a 2-entry valid/ready skid buffer. With bypass compiled in, it forwards same-cycle regfile writes and snoops later writebacks into buffered entries, so buffered operands never go stale.

---
 rtl/id_operand_stage.sv | 145 ++++++++++++++
 tb/tb_id_operand_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: regfile read, operand capture and a 2-entry skid buffer.
// Define OPERAND_BYPASS_EN to forward same-cycle writebacks and snoop them into buffered operands.
module id_operand_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic [5:0]        in_op,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [ADDR_W-1:0] in_dest,
   input  logic              in_dest_we,
   output logic [ADDR_W-1:0] r_addr1,
   output logic [ADDR_W-1:0] r_addr2,
   input  logic [DATA_W-1:0] r_data1,
   input  logic [DATA_W-1:0] r_data2,
   input  logic              wb_enable,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [DATA_W-1:0] out_imm,
   output logic [5:0]        out_op,
   output logic [ADDR_W-1:0] out_dest,
   output logic              out_dest_we
);

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [ADDR_W-1:0] rs;
      logic [ADDR_W-1:0] rt;
      logic [DATA_W-1:0] imm;
      logic [5:0]        op;
      logic [ADDR_W-1:0] dest;
      logic              dest_we;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t state;
   entry_t head, tail;
   entry_t new_e, head_s, tail_s;
   logic   accept, dequeue;

   assign r_addr1 = in_rs;
   assign r_addr2 = in_rt;

   assign accept    = in_valid && in_ready;
   assign out_valid = (state != EMPTY);
   assign dequeue   = out_valid && out_ready;

   assign out_a       = head.a;
   assign out_b       = head.b;
   assign out_imm     = head.imm;
   assign out_op      = head.op;
   assign out_dest    = head.dest;
   assign out_dest_we = head.dest_we;

   // NOTE: every always_comb output gets a full default first so no latch is inferred.
   always_comb begin
      new_e = '{a: r_data1, b: r_data2, rs: in_rs, rt: in_rt, imm: in_imm,
                op: in_op, dest: in_dest, dest_we: in_dest_we};
      head_s = head;
      tail_s = tail;
`ifdef OPERAND_BYPASS_EN
      if (wb_enable && wb_addr != '0) begin
         if (wb_addr == in_rs) new_e.a = wb_data;
         if (wb_addr == in_rt) new_e.b = wb_data;
         if (state != EMPTY && head.rs == wb_addr) head_s.a = wb_data;
         if (state != EMPTY && head.rt == wb_addr) head_s.b = wb_data;
         if (state == TWO && tail.rs == wb_addr) tail_s.a = wb_data;
         if (state == TWO && tail.rt == wb_addr) tail_s.b = wb_data;
      end
`endif
      // Register 0 reads as zero regardless of regfile or writeback contents.
      if (in_rs == '0) new_e.a = '0;
      if (in_rt == '0) new_e.b = '0;
   end

`ifndef OPERAND_BYPASS_EN
   // Without bypass the writeback port and stored source numbers have no reader.
   logic unused_snoop;
   assign unused_snoop = ^{wb_enable, wb_addr, wb_data, head.rs, head.rt, tail.rs, tail.rt};
`endif

   // NOTE: buffer entries are reset too, because the data outputs must read zero out of reset.
   // NOTE: sequential state uses non-blocking assignments only, so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
         head     <= '0;
         tail     <= '0;
      end else if (flush) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  head  <= new_e;
                  state <= ONE;
               end
            end
            ONE: begin
               if (accept && dequeue) begin
                  head <= new_e;
               end else if (accept) begin
                  head     <= head_s;
                  tail     <= new_e;
                  state    <= TWO;
                  in_ready <= 1'b0;
               end else if (dequeue) begin
                  state <= EMPTY;
               end else begin
                  head <= head_s;
               end
            end
            TWO: begin
               if (dequeue) begin
                  head     <= tail_s;
                  state    <= ONE;
                  in_ready <= 1'b1;
               end else begin
                  head <= head_s;
                  tail <= tail_s;
               end
            end
            default: begin
               state    <= EMPTY;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with a queue scoreboard of expected operand entries.
module tb_id_operand_stage;

`ifdef OPERAND_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs, in_rt, in_dest;
   logic [5:0]  in_op;
   logic [31:0] in_imm;
   logic        in_dest_we;
   logic [4:0]  r_addr1, r_addr2;
   logic [31:0] r_data1, r_data2;
   logic        wb_enable;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_a, out_b, out_imm;
   logic [5:0]  out_op;
   logic [4:0]  out_dest;
   logic        out_dest_we;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a, b, imm;
      logic [4:0]  rs, rt, dest;
      logic [5:0]  op;
      logic        we;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   logic m_acc, m_deq;

   always #5 clk = ~clk;

   id_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_op(in_op), .in_imm(in_imm),
      .in_dest(in_dest), .in_dest_we(in_dest_we), .r_addr1(r_addr1), .r_addr2(r_addr2),
      .r_data1(r_data1), .r_data2(r_data2), .wb_enable(wb_enable), .wb_addr(wb_addr),
      .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_op(out_op),
      .out_dest(out_dest), .out_dest_we(out_dest_we)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t capture();
      exp_t e;
      e.rs = in_rs; e.rt = in_rt; e.imm = in_imm; e.op = in_op;
      e.dest = in_dest; e.we = in_dest_we;
      e.a = (BYP && wb_enable && wb_addr == in_rs) ? wb_data : r_data1;
      e.b = (BYP && wb_enable && wb_addr == in_rt) ? wb_data : r_data2;
      if (in_rs == 5'd0) e.a = 32'd0;
      if (in_rt == 5'd0) e.b = 32'd0;
      return e;
   endfunction

   // Scoreboard: own occupancy model, pops on dequeue, snoops survivors, pushes on accept.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         check("in_ready", in_ready, sb.size() < 2);
         check("out_valid", out_valid, sb.size() > 0);
         m_deq = (sb.size() > 0) && out_ready;
         m_acc = in_valid && (sb.size() < 2);
         if (m_deq) begin
            got = sb.pop_front();
            check("sb_a", out_a, got.a);
            check("sb_b", out_b, got.b);
            check("sb_imm", out_imm, got.imm);
            check("sb_op", out_op, got.op);
            check("sb_dest", {out_dest_we, out_dest}, {got.we, got.dest});
         end
         if (flush) begin
            sb.delete();
         end else begin
            if (BYP && wb_enable && wb_addr != 5'd0) begin
               foreach (sb[i]) begin
                  if (sb[i].rs == wb_addr) sb[i].a = wb_data;
                  if (sb[i].rt == wb_addr) sb[i].b = wb_data;
               end
            end
            if (m_acc) sb.push_back(capture());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [5:0] op, input logic [4:0] dest, input logic we);
      in_valid = v; in_rs = rs; in_rt = rt; r_data1 = d1; r_data2 = d2;
      in_imm = imm; in_op = op; in_dest = dest; in_dest_we = we;
   endtask

   task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
      wb_enable = en; wb_addr = addr; wb_data = data;
   endtask

   task automatic idle();
      offer(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      idle();
      wb(1'b0, 5'd0, 32'd0);
      tick(); tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_a", out_a, 32'd0);
      check("rst_out_imm", out_imm, 32'd0);
      rst_n = 1'b1;

      // Reset in the middle of a full buffer.
      out_ready = 1'b0;
      offer(1'b1, 5'd2, 5'd3, 32'h22, 32'h33, 32'h10, 6'd4, 5'd6, 1'b1);
      #1;
      check("r_addr1", r_addr1, 5'd2);
      check("r_addr2", r_addr2, 5'd3);
      tick();
      offer(1'b1, 5'd4, 5'd1, 32'h44, 32'h11, 32'h20, 6'd5, 5'd7, 1'b0);
      tick();
      check("two_in_ready", in_ready, 1'b0);
      idle();
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_a", out_a, 32'd0);
      check("midrst_out_dest", out_dest, 5'd0);
      tick();
      rst_n = 1'b1;

      // First-instruction latency.
      offer(1'b1, 5'd3, 5'd1, 32'h11, 32'h5, 32'h1234, 6'h2A, 5'd9, 1'b0);
      tick();
      check("lat_out_valid", out_valid, 1'b1);
      check("lat_out_a", out_a, 32'h11);
      check("lat_out_op", out_op, 6'h2A);
      idle();
      out_ready = 1'b1;
      tick();
      check("lat_drained", out_valid, 1'b0);

      // Backpressure with three offered instructions.
      out_ready = 1'b0;
      offer(1'b1, 5'd1, 5'd2, 32'h101, 32'h102, 32'h1, 6'd1, 5'd1, 1'b1);
      tick();
      check("bp_ready_one", in_ready, 1'b1);
      offer(1'b1, 5'd3, 5'd4, 32'h202, 32'h204, 32'h2, 6'd2, 5'd2, 1'b1);
      tick();
      check("bp_ready_two", in_ready, 1'b0);
      offer(1'b1, 5'd5, 5'd6, 32'h303, 32'h306, 32'h3, 6'd3, 5'd3, 1'b1);
      tick();
      check("bp_hold_ready", in_ready, 1'b0);
      check("bp_hold_head", out_a, 32'h101);
      out_ready = 1'b1;
      tick();
      check("bp_ready_back", in_ready, 1'b1);
      check("bp_second_head", out_a, 32'h202);
      tick();
      check("bp_third_head", out_a, 32'h303);
      idle();
      tick();
      check("bp_drained", out_valid, 1'b0);

      // Register 0 reads as zero.
      out_ready = 1'b0;
      offer(1'b1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 6'd7, 5'd0, 1'b0);
      tick();
      check("r0_out_a", out_a, 32'd0);
      check("r0_out_b", out_b, 32'd0);
      idle();
      out_ready = 1'b1;
      tick();

      // Same-cycle forward.
      out_ready = 1'b0;
      offer(1'b1, 5'd5, 5'd6, 32'hAAAA, 32'h6, 32'h0, 6'd8, 5'd5, 1'b1);
      wb(1'b1, 5'd5, 32'h1234);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      check("fwd_out_a", out_a, BYP ? 32'h1234 : 32'hAAAA);
      check("fwd_out_b", out_b, 32'h6);
      idle();
      out_ready = 1'b1;
      tick();

      // Snoop into a held head, then into an entry moving tail to head.
      out_ready = 1'b0;
      offer(1'b1, 5'd0, 5'd7, 32'h55, 32'h1, 32'h0, 6'd9, 5'd8, 1'b1);
      tick();
      idle();
      tick(); tick();
      wb(1'b1, 5'd7, 32'hBEEF);
      tick();
      wb(1'b1, 5'd0, 32'h777);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      check("snoop_out_b", out_b, BYP ? 32'hBEEF : 32'h1);
      check("snoop_r0_a", out_a, 32'd0);
      offer(1'b1, 5'd9, 5'd2, 32'h99, 32'h2, 32'h0, 6'd10, 5'd9, 1'b0);
      tick();
      idle();
      out_ready = 1'b1;
      wb(1'b1, 5'd9, 32'hCAFE);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      check("snoop_tail_a", out_a, BYP ? 32'hCAFE : 32'h99);
      tick();
      check("snoop_drained", out_valid, 1'b0);

      // Flush in TWO with an offered instruction, in ONE with accept, and with dequeue.
      out_ready = 1'b0;
      offer(1'b1, 5'd1, 5'd1, 32'hA1, 32'hA1, 32'h0, 6'd11, 5'd1, 1'b1);
      tick();
      offer(1'b1, 5'd2, 5'd2, 32'hB2, 32'hB2, 32'h0, 6'd12, 5'd2, 1'b1);
      tick();
      offer(1'b1, 5'd3, 5'd3, 32'hC3, 32'hC3, 32'h0, 6'd13, 5'd3, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush2_out_valid", out_valid, 1'b0);
      check("flush2_in_ready", in_ready, 1'b1);
      offer(1'b1, 5'd4, 5'd4, 32'hD4, 32'hD4, 32'h0, 6'd14, 5'd4, 1'b1);
      tick();
      offer(1'b1, 5'd5, 5'd5, 32'hE5, 32'hE5, 32'h0, 6'd15, 5'd5, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush1_out_valid", out_valid, 1'b0);
      offer(1'b1, 5'd6, 5'd6, 32'hF6, 32'hF6, 32'h0, 6'd16, 5'd6, 1'b1);
      tick();
      idle();
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flushdq_out_valid", out_valid, 1'b0);
      tick(); tick();

      // Back-to-back stream with random operands and writebacks.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         offer(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom, $urandom,
               $urandom, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         tick();
         check("stream_in_ready", in_ready, 1'b1);
         check("stream_out_valid", out_valid, 1'b1);
      end
      idle();
      wb(1'b0, 5'd0, 32'd0);
      tick(); tick();

      check("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
